// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and alignment helper.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DROP  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit_out_reg.sv
// Fetch output register toward decode; flush beats capture, capture beats consume.
module fetch_unit_out_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rest_ni,
  input  logic              capture_i,
  input  logic              consume_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  logic [DATA_W-1:0] inst_d, inst_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              valid_d, valid_q;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      inst_d  = data_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rest_ni) begin
    if (!rest_ni) begin
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = pc_q;
  assign inst_valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem transaction, output register to decode, pc step pulse.
//   state | meaning
//   IDLE  | first cycle after reset
//   REQ   | presenting pc_addr to imem (suppressed when misaligned or decode is stalled)
//   WAIT  | granted, waiting for rvalid
//   HOLD  | decode has not taken the held instruction yet
//   DROP  | flushed in flight, swallow the next rvalid
//   FAULT | misaligned pc seen, parked until flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rest_ni,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic              pc_adv_o,
  fetch_unit_if.master      imem,
  input  logic              id_ready_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              fault_o
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              fault_q;

  logic misaligned;
  logic blocked;
  logic req_ok;
  logic handshake;
  logic capture;
  logic consume;

  assign misaligned = CHECK_ALIGN && is_misaligned(pc_addr_i[1:0]);
  // A held instruction decode cannot take yet must not be overwritten, so no request.
  assign blocked    = inst_valid_o && !id_ready_i;
  assign req_ok     = (state_q == ST_REQ) && !misaligned && !blocked;
  assign handshake  = req_ok && imem.gnt;
  assign capture    = (state_q == ST_WAIT) && imem.rvalid && !flush_i;
  assign consume    = inst_valid_o && id_ready_i;

  assign imem.req  = req_ok;
  assign imem.addr = req_ok ? pc_addr_i : '0;
  assign pc_adv_o  = capture;
  assign fault_o   = fault_q;

  always_ff @(posedge clk_i or negedge rest_ni) begin
    if (!rest_ni) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (handshake) begin
        req_pc_q <= pc_addr_i;
      end
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (flush_i) begin
            if (handshake) begin
              state_q <= ST_DROP;
            end
          end else if (misaligned) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else if (blocked) begin
            state_q <= ST_HOLD;
          end else if (handshake) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            state_q <= ST_REQ;
          end else if (flush_i) begin
            state_q <= ST_DROP;
          end
        end
        ST_HOLD: begin
          if (flush_i || id_ready_i) begin
            state_q <= ST_REQ;
          end
        end
        // A flush here changes nothing: the old response is still owed.
        ST_DROP: begin
          if (imem.rvalid) begin
            state_q <= ST_REQ;
          end
        end
        ST_FAULT: begin
          if (flush_i) begin
            fault_q <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_unit_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk_i        (clk_i),
    .rest_ni      (rest_ni),
    .capture_i    (capture),
    .consume_i    (consume),
    .flush_i      (flush_i),
    .data_i       (imem.rdata),
    .pc_i         (req_pc_q),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable grant/response delay, pc model, capture scoreboard.
module tb_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rest_n;
  logic [31:0] pc_addr;
  logic        id_ready;
  logic        flush;
  logic        pc_adv;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fault;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem ();

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHECK_ALIGN(1'b1)) dut (
    .clk_i        (clk),
    .rest_ni      (rest_n),
    .pc_addr_i    (pc_addr),
    .pc_adv_o     (pc_adv),
    .imem         (imem),
    .id_ready_i   (id_ready),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid),
    .fault_o      (fault)
  );

  // memory model
  logic        gnt_en;
  int          gnt_delay;
  int          rdelay;
  int          wcnt;
  logic        pend;
  int          rcnt;
  logic [31:0] raddr_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h1357};
  endfunction

  assign imem.gnt    = imem.req && gnt_en && (wcnt >= gnt_delay);
  assign imem.rvalid = rvalid_q;
  assign imem.rdata  = rdata_q;

  always @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      wcnt <= 0; pend <= 1'b0; rcnt <= 0; raddr_q <= '0; rvalid_q <= 1'b0; rdata_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wcnt <= (imem.req && !imem.gnt && gnt_en) ? wcnt + 1 : 0;
      if (imem.req && imem.gnt) begin
        if (rdelay <= 1) begin
          rvalid_q <= 1'b1;
          rdata_q  <= mem_word(imem.addr);
        end else begin
          pend    <= 1'b1;
          rcnt    <= rdelay - 1;
          raddr_q <= imem.addr;
        end
      end else if (pend) begin
        if (rcnt == 1) begin
          rvalid_q <= 1'b1;
          rdata_q  <= mem_word(raddr_q);
          pend     <= 1'b0;
        end else begin
          rcnt <= rcnt - 1;
        end
      end
    end
  end

  // scoreboard and bookkeeping
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          cap_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          n_adv = 0;
  int          n_cap = 0;
  int          first_req = -1;
  logic [31:0] first_addr = '0;
  logic        mark_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_cons = 1'b0;
  logic        s_req, s_adv, s_valid, s_fault;
  logic [31:0] s_addr, s_inst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    cyc_n++;
    s_req   = imem.req;
    s_addr  = imem.addr;
    s_adv   = pc_adv;
    s_valid = inst_valid;
    s_fault = fault;
    s_inst  = inst;
    if (pc_adv) n_adv++;
    if (imem.req) begin
      chk("req_addr", imem.addr, pc_addr);
      chk("req_aligned", imem.addr[1:0], 2'b00);
    end else begin
      chk("idle_addr", imem.addr, 32'h0);
    end
    if (mark_req && imem.req) begin
      first_req  = cyc_n;
      first_addr = imem.addr;
      mark_req   = 1'b0;
    end
    if (inst_valid && (!prev_valid || prev_cons)) begin
      n_cap++;
      cap_cyc.push_back(cyc_n);
      chk("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.data);
      end
    end
    prev_valid = inst_valid;
    prev_cons  = inst_valid && id_ready;
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (s_adv) pc_addr = pc_addr + 32'd4;
  endtask

  task automatic fetch_until(input int adv_target, input int limit, input string tag);
    int g;
    g = 0;
    while (n_adv < adv_target && g < limit) begin
      cyc();
      g++;
    end
    gnt_en = 1'b0;
    chk(tag, n_adv >= adv_target, 1'b1);
  endtask

  initial begin
    int a0, c0, g, nreq;
    rest_n = 1'b1; pc_addr = 32'h0; id_ready = 1'b1; flush = 1'b0;
    gnt_en = 1'b1; gnt_delay = 0; rdelay = 1;
    #1 rest_n = 1'b0;
    #1;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_req", imem.req, 1'b0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_pc_adv", pc_adv, 1'b0);
    repeat (2) @(posedge clk);
    #1 rest_n = 1'b1;

    // 1: zero-wait memory, three back-to-back fetches
    mark_req = 1'b1;
    cap_cyc.delete();
    a0 = n_adv; c0 = n_cap;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    fetch_until(a0 + 3, 40, "t1_timeout");
    repeat (3) cyc();
    chk("t1_adv_count", n_adv - a0, 3);
    chk("t1_cap_count", n_cap - c0, 3);
    if (cap_cyc.size() >= 3) begin
      chk("t1_latency", cap_cyc[0] - first_req, 2);
      chk("t1_spacing1", cap_cyc[1] - cap_cyc[0], 2);
      chk("t1_spacing2", cap_cyc[2] - cap_cyc[1], 2);
    end

    // 2: decode backpressure holds the instruction and blocks requests
    a0 = n_adv;
    push_exp(32'hC);
    gnt_en = 1'b1;
    fetch_until(a0 + 1, 20, "t2_timeout");
    id_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("t2_valid_held", s_valid, 1'b1);
      chk("t2_inst_stable", s_inst, mem_word(32'hC));
      chk("t2_no_req", s_req, 1'b0);
      chk("t2_no_adv", s_adv, 1'b0);
    end
    id_ready = 1'b1;
    cyc();
    chk("t2_req_low_on_release", s_req, 1'b0);
    cyc();
    chk("t2_req_after_release", s_req, 1'b1);
    chk("t2_req_addr", s_addr, 32'h10);

    // 3: grant delayed three cycles, address held stable
    flush = 1'b1; pc_addr = 32'h40;
    cyc();
    chk("t3_flush_no_adv", s_adv, 1'b0);
    flush = 1'b0; gnt_delay = 3; gnt_en = 1'b1;
    push_exp(32'h40);
    a0 = n_adv; c0 = n_cap; g = 0; nreq = 0;
    while (n_adv < a0 + 1 && g < 20) begin
      cyc();
      g++;
      if (s_req) begin
        nreq++;
        chk("t3_addr_held", s_addr, 32'h40);
      end
    end
    gnt_en = 1'b0;
    chk("t3_done", n_adv >= a0 + 1, 1'b1);
    chk("t3_req_cycles", nreq, 4);
    gnt_delay = 0;
    repeat (2) cyc();
    chk("t3_single_cap", n_cap - c0, 1);

    // 4: flush one cycle after grant, stale response dropped
    rdelay = 3; gnt_en = 1'b1; a0 = n_adv;
    cyc();
    chk("t4_granted_req", s_req, 1'b1);
    flush = 1'b1; pc_addr = 32'h100;
    cyc();
    chk("t4_flush_no_adv", s_adv, 1'b0);
    flush = 1'b0; rdelay = 1;
    repeat (2) begin
      cyc();
      chk("t4_drop_no_req", s_req, 1'b0);
      chk("t4_drop_no_adv", s_adv, 1'b0);
      chk("t4_drop_invalid", s_valid, 1'b0);
    end
    push_exp(32'h100);
    fetch_until(a0 + 1, 20, "t4_timeout");
    cyc();
    chk("t4_adv_count", n_adv - a0, 1);

    // 5: misaligned pc faults until flushed
    flush = 1'b1; pc_addr = 32'h102;
    cyc();
    chk("t5_flush_misaligned_no_req", s_req, 1'b0);
    flush = 1'b0; gnt_en = 1'b1;
    cyc();
    chk("t5_misaligned_no_req", s_req, 1'b0);
    repeat (3) begin
      cyc();
      chk("t5_fault_set", s_fault, 1'b1);
      chk("t5_fault_no_req", s_req, 1'b0);
      chk("t5_fault_no_adv", s_adv, 1'b0);
    end
    flush = 1'b1; pc_addr = 32'h104;
    cyc();
    flush = 1'b0; a0 = n_adv;
    push_exp(32'h104);
    cyc();
    chk("t5_fault_cleared", s_fault, 1'b0);
    chk("t5_resume_req", s_req, 1'b1);
    fetch_until(a0 + 1, 20, "t5_timeout");
    cyc();

    // 6: asynchronous reset in the middle of WAIT
    rdelay = 3; gnt_en = 1'b1;
    cyc();
    chk("t6_granted_req", s_req, 1'b1);
    #2 rest_n = 1'b0;
    #1;
    chk("t6_rst_inst_valid", inst_valid, 1'b0);
    chk("t6_rst_inst", inst, 32'h0);
    chk("t6_rst_inst_pc", inst_pc, 32'h0);
    chk("t6_rst_fault", fault, 1'b0);
    chk("t6_rst_req", imem.req, 1'b0);
    chk("t6_rst_addr", imem.addr, 32'h0);
    chk("t6_rst_pc_adv", pc_adv, 1'b0);
    pc_addr = 32'h200; rdelay = 1;
    repeat (2) cyc();
    rest_n = 1'b1;
    mark_req = 1'b1; a0 = n_adv;
    push_exp(32'h200);
    fetch_until(a0 + 1, 20, "t6_timeout");
    cyc();
    chk("t6_first_req_addr", first_addr, 32'h200);

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
